counter_sched: RTL and testbench

Round-robin scheduler that shares one W-bit interval counter between N requesters. Each requester asks for a timed interval of a programmable length. The block grants the counter to one requester at a time, counts the interval, and signals completion with a one-cycle done pulse. It sits between the counter datapath and the client blocks that need timed windows.

---
 rtl/counter_sched.sv | 167 ++++++++++++++++
 tb/tb_counter_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched -- round-robin scheduler sharing one W-bit interval counter
// between N requesters.
//
// A requester raises req[i] with its interval length on len[i*W +: W]. In
// IDLE the first active request at or after the rotating pointer wins; its
// length is latched, grant is held for exactly L cycles while value counts
// 0..L-1, then done pulses for one cycle and the block returns to IDLE.
// A zero-length request skips RUN and produces only the done pulse.
//
// Optional feature (macro COUNTER_SCHED_ABORT_EN): when defined, dropping
// req[owner] during RUN aborts the interval (back to IDLE, no done pulse).
//
// Parameters:
//   N  number of requesters (2..8)
//   W  counter / interval length width
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   req    [N]    request levels
//   len    [N*W]  interval lengths, sampled at grant
//   grant  [N]    one-hot, high during the owner's RUN cycles
//   done   [N]    one-hot, single-cycle completion pulse
//   busy          high in RUN and DONE
//   value  [W]    current counter value
module counter_sched #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] len,
   output logic [N-1:0]   grant,
   output logic [N-1:0]   done,
   output logic           busy,
   output logic [W-1:0]   value
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   logic [1:0]    state_reg;
   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] owner_reg;
   logic [W-1:0]  len_reg;
   logic [W-1:0]  value_reg;
   logic [N-1:0]  grant_reg;
   logic [N-1:0]  done_reg;

   // Per-slot views: unpacked lengths and the requester index examined at
   // search position gi, i.e. (ptr + gi) mod N.
   logic [W-1:0]  len_arr  [N];
   logic [PW-1:0] cand_idx [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slot
         logic [PW:0] sum;
         assign len_arr[gi]  = len[gi*W +: W];
         assign sum          = {1'b0, ptr_reg} + (PW+1)'(gi);
         assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                                    : sum[PW-1:0];
      end
   endgenerate

   logic          win_found;
   logic [PW-1:0] win_idx;
   logic [W-1:0]  win_len;
   logic [N-1:0]  win_onehot;
   logic [N-1:0]  owner_onehot;
   logic [PW-1:0] ptr_next;
   logic          run_last;

   // Scan from the farthest position back to the pointer so the last hit,
   // which is the one nearest the pointer, is the winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[cand_idx[k]]) begin
            win_found = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   assign win_len      = len_arr[win_idx];
   assign win_onehot   = ONE_HOT0 << win_idx;
   assign owner_onehot = ONE_HOT0 << owner_reg;
   assign ptr_next     = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
   // len_reg is non-zero whenever RUN is entered, so L-1 cannot underflow.
   assign run_last     = (value_reg == len_reg - W'(1));

   logic abort;
`ifdef COUNTER_SCHED_ABORT_EN
   assign abort = ~req[owner_reg];
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         owner_reg <= '0;
         len_reg   <= '0;
         value_reg <= '0;
         grant_reg <= '0;
         done_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (win_found) begin
                  owner_reg <= win_idx;
                  len_reg   <= win_len;
                  ptr_reg   <= ptr_next;
                  value_reg <= '0;
                  if (win_len != '0) begin
                     state_reg <= ST_RUN;
                     grant_reg <= win_onehot;
                  end else begin
                     // Zero-length interval: completion only, no grant cycle.
                     state_reg <= ST_DONE;
                     done_reg  <= win_onehot;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
                  grant_reg <= '0;
                  value_reg <= '0;
               end else if (run_last) begin
                  // value holds at L-1 through the DONE cycle.
                  state_reg <= ST_DONE;
                  grant_reg <= '0;
                  done_reg  <= owner_onehot;
               end else begin
                  value_reg <= value_reg + W'(1);
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               done_reg  <= '0;
               value_reg <= '0;
            end
            default: begin
               state_reg <= ST_IDLE;
               grant_reg <= '0;
               done_reg  <= '0;
               value_reg <= '0;
            end
         endcase
      end
   end

   assign grant = grant_reg;
   assign done  = done_reg;
   assign busy  = (state_reg == ST_RUN) || (state_reg == ST_DONE);
   assign value = value_reg;

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched: a trace-level model (per-interval expected
// output sequences kept in a queue) checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_counter_sched;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] len;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   value;

   int checks = 0;
   int errors = 0;

   counter_sched #(.N(N), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .value (value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct packed {
      logic [N-1:0] g;
      logic [N-1:0] d;
      logic         b;
      logic [W-1:0] v;
      logic         run;
   } exp_t;

   exp_t q[$];
   exp_t cur = '0;
   exp_t e;
   int   m_ptr = 0;
   int   m_owner = 0;
   int   m_win;
   int   m_len;
   bit   started = 0;
   bit   m_abort;
   logic [N-1:0] m_oh;

   // On each edge produce the outputs expected right after that edge.
   // When no interval is pending the DUT is idle and arbitrates.
   always @(posedge clk) begin
      started = 1;
      if (reset) begin
         q.delete();
         m_ptr = 0;
         cur   = '0;
      end else begin
         m_abort = 0;
`ifdef COUNTER_SCHED_ABORT_EN
         if (cur.run && !req[m_owner]) m_abort = 1;
`endif
         if (m_abort) begin
            q.delete();
            cur = '0;
         end else if (q.size() > 0) begin
            cur = q.pop_front();
         end else if (req != '0) begin
            m_win = -1;
            for (int k = 0; k < N; k++) begin
               if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            end
            m_owner = m_win;
            m_ptr   = (m_win + 1) % N;
            m_len   = int'(len[m_win*W +: W]);
            m_oh    = '0;
            m_oh[m_win] = 1'b1;
            for (int k = 0; k < m_len; k++) begin
               e = '0; e.g = m_oh; e.b = 1'b1; e.v = W'(k); e.run = 1'b1;
               q.push_back(e);
            end
            e = '0; e.d = m_oh; e.b = 1'b1; e.v = (m_len == 0) ? '0 : W'(m_len - 1);
            q.push_back(e);
            e = '0;
            q.push_back(e);
            cur = q.pop_front();
         end else begin
            cur = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_grant", grant, cur.g);
         chk("model_done",  done,  cur.d);
         chk("model_busy",  busy,  cur.b);
         chk("model_value", value, cur.v);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      tick(2);
      reset = 1'b0;
   endtask

   int t1_g [5] = '{1, 1, 1, 0, 0};
   int t1_d [5] = '{0, 0, 0, 1, 0};
   int t1_v [5] = '{0, 1, 2, 2, 0};
   int t1_b [5] = '{1, 1, 1, 1, 0};
   int t2_g [5] = '{1, 2, 4, 8, 1};
   int t2_c [5] = '{1, 5, 9, 13, 17};

   int ns;
   int gcnt;
   int dcnt;
   logic [N-1:0] prev_g;

   initial begin
      reset = 1'b1;
      req   = '0;
      len   = '0;
      tick(2);
      chk("reset_grant", grant, 0);
      chk("reset_done",  done,  0);
      chk("reset_busy",  busy,  0);
      chk("reset_value", value, 0);
      reset = 1'b0;

      // Single request, L=3.
      len[0*W +: W] = 8'd3;
      req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t1_grant", grant, t1_g[i]);
         chk("t1_done",  done,  t1_d[i]);
         chk("t1_value", value, t1_v[i]);
         chk("t1_busy",  busy,  t1_b[i]);
         if (i == 3) req = '0;
      end
      $display("t1 single request L=3 done");

      // All four requesting, L=2 each: rotation and 4-cycle period.
      do_reset();
      for (int i = 0; i < N; i++) len[i*W +: W] = 8'd2;
      req = 4'b1111;
      ns = 0;
      prev_g = '0;
      for (int c = 1; c <= 18; c++) begin
         tick(1);
         if (grant != '0 && prev_g == '0 && ns < 5) begin
            chk("t2_grant_order", grant, t2_g[ns]);
            chk("t2_grant_cycle", c, t2_c[ns]);
            ns++;
         end
         prev_g = grant;
      end
      chk("t2_grant_count", ns, 5);
      $display("t2 round robin saw %0d grant starts", ns);

      // Zero-length request.
      do_reset();
      len = '0;
      req = 4'b0100;
      tick(1);
      chk("t3_done",  done,  4'b0100);
      chk("t3_grant", grant, 0);
      chk("t3_busy",  busy,  1);
      req = '0;
      tick(1);
      chk("t3_done_end", done, 0);
      tick(1);
      chk("t3_idle_busy", busy, 0);
      $display("t3 zero-length request done");

      // Reset during RUN at value=5, then ptr back to 0.
      do_reset();
      len[0*W +: W] = 8'd10;
      req = 4'b0001;
      tick(6);
      chk("t4_pre_value", value, 5);
      chk("t4_pre_grant", grant, 4'b0001);
      reset = 1'b1;
      tick(1);
      chk("t4_grant", grant, 0);
      chk("t4_value", value, 0);
      chk("t4_done",  done,  0);
      chk("t4_busy",  busy,  0);
      reset = 1'b0;
      len[0*W +: W] = 8'd1;
      len[1*W +: W] = 8'd1;
      req = 4'b0011;
      tick(1);
      chk("t4_first_winner", grant, 4'b0001);
      tick(8);
      $display("t4 reset mid-run done");

      // len change after grant is ignored.
      do_reset();
      len[0*W +: W] = 8'd4;
      req = 4'b0001;
      tick(1);
      len[0*W +: W] = 8'd9;
      gcnt = (grant == 4'b0001) ? 1 : 0;
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (grant[0]) gcnt++;
         if (done[0]) begin
            dcnt++;
            req = '0;
         end
      end
      chk("t5_grant_cycles", gcnt, 4);
      chk("t5_done_pulses",  dcnt, 1);
      $display("t5 len change after grant: %0d grant cycles", gcnt);

      // Request dropped at value=1, L=6.
      do_reset();
      len[0*W +: W] = 8'd6;
      req = 4'b0001;
      tick(2);
      chk("t6_pre_value", value, 1);
      req = '0;
      gcnt = 0;
      dcnt = 0;
      tick(1);
`ifdef COUNTER_SCHED_ABORT_EN
      chk("t6_abort_grant", grant, 0);
      chk("t6_abort_value", value, 0);
`else
      chk("t6_run_value", value, 2);
`endif
      if (grant[0]) gcnt++;
      if (done[0]) dcnt++;
      for (int i = 0; i < 11; i++) begin
         tick(1);
         if (grant[0]) gcnt++;
         if (done[0]) dcnt++;
      end
`ifdef COUNTER_SCHED_ABORT_EN
      chk("t6_grant_after_drop", gcnt, 0);
      chk("t6_done_pulses",      dcnt, 0);
`else
      chk("t6_grant_after_drop", gcnt, 4);
      chk("t6_done_pulses",      dcnt, 1);
`endif
      $display("t6 request drop: %0d grant cycles after drop, %0d done", gcnt, dcnt);

      // Mixed lengths including zero, then a request pattern change.
      do_reset();
      len = {8'd1, 8'd0, 8'd3, 8'd2};
      req = 4'b1111;
      tick(40);
      req = 4'b1010;
      tick(20);
      do_reset();
      $display("t7 mixed lengths done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
